// File: rtl/axi_sram_slave.sv
// AXI single-outstanding SRAM slave: 2^ADDR_W x 32-bit words, INCR/FIXED bursts, byte strobes.
// Define AXI_SLAVE_STALL_EN to add LFSR-driven back-pressure on ready and R/B valid.
module axi_sram_slave #(
  parameter int ADDR_W    = 10,
  parameter int INIT_ZERO = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          DEPTH       = 1 << ADDR_W;
  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] INIT_WORD   = (INIT_ZERO != 0) ? 32'h0 : 32'hxxxx_xxxx;

  typedef enum logic [2:0] {IDLE, RD_MEM, RD_RESP, WR_DATA, WR_RESP} state_t;

  state_t            state, next_state;
  logic [31:0]       mem [DEPTH] = '{default: INIT_WORD};
  logic [ADDR_W-1:0] addr, next_addr;
  logic [7:0]        len, beat;
  logic [1:0]        burst;
  logic              gate, r_hold, b_hold;
  logic              aw_take, ar_take, r_take, w_take, b_take;
  logic              burst_ok, last_beat, w_end;
  logic              unused;

  assign unused = ^{wid, arsize, awsize, araddr[31:ADDR_W+2], araddr[1:0],
                    awaddr[31:ADDR_W+2], awaddr[1:0]};

`ifdef AXI_SLAVE_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr   <= 16'hACE1;
      r_hold <= 1'b0;
      b_hold <= 1'b0;
    end else begin
      lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      // Once shown, a valid stays up until its handshake regardless of the LFSR.
      r_hold <= rvalid && !rready;
      b_hold <= bvalid && !bready;
    end
  end

  assign gate = lfsr[0];
`else
  assign gate   = 1'b1;
  assign r_hold = 1'b0;
  assign b_hold = 1'b0;
`endif

  assign arready = (state == IDLE) && gate;
  assign awready = (state == IDLE) && gate;
  assign wready  = (state == WR_DATA) && gate;
  assign rvalid  = (state == RD_RESP) && (gate || r_hold);
  assign bvalid  = (state == WR_RESP) && (gate || b_hold);

  assign burst_ok  = (burst == BURST_INCR) || (burst == BURST_FIXED);
  assign next_addr = (burst == BURST_INCR) ? addr + 1'b1 : addr;
  assign last_beat = (beat == len);
  assign rlast     = (state == RD_RESP) && last_beat;
  assign w_end     = wlast || last_beat;

  // Write wins a tie; the read stays pending until the next IDLE cycle.
  assign aw_take = awvalid && awready;
  assign ar_take = arvalid && arready && !awvalid;
  assign r_take  = rvalid && rready;
  assign w_take  = wvalid && wready;
  assign b_take  = bvalid && bready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets its default first, so no path through the case can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (aw_take)      next_state = WR_DATA;
        else if (ar_take) next_state = RD_MEM;
      end
      RD_MEM:  next_state = RD_RESP;
      RD_RESP: if (r_take) next_state = last_beat ? IDLE : RD_MEM;
      WR_DATA: if (w_take && w_end) next_state = WR_RESP;
      WR_RESP: if (b_take) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr  <= '0;
      len   <= '0;
      beat  <= '0;
      burst <= BURST_FIXED;
      rid   <= '0;
      bid   <= '0;
      rdata <= '0;
      rresp <= RESP_OKAY;
      bresp <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (aw_take) begin
            bid   <= awid;
            addr  <= awaddr[ADDR_W+1:2];
            len   <= awlen;
            burst <= awburst;
            beat  <= '0;
          end else if (ar_take) begin
            rid   <= arid;
            addr  <= araddr[ADDR_W+1:2];
            len   <= arlen;
            burst <= arburst;
            beat  <= '0;
            rresp <= (arburst == BURST_INCR || arburst == BURST_FIXED) ? RESP_OKAY : RESP_SLVERR;
          end
        end
        RD_MEM: rdata <= mem[addr];
        RD_RESP: begin
          if (r_take) begin
            addr <= next_addr;
            beat <= beat + 8'd1;
          end
        end
        WR_DATA: begin
          if (w_take) begin
            addr <= next_addr;
            beat <= beat + 8'd1;
            // A wlast that disagrees with the beat count is flagged, whichever comes first.
            if (w_end)
              bresp <= (!burst_ok || (wlast != last_beat)) ? RESP_SLVERR : RESP_OKAY;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the storage array is never reset, so written words survive a reset and map onto plain SRAM.
  always_ff @(posedge clk) begin
    if (state == WR_DATA && w_take && burst_ok) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave (default build, ADDR_W=10, INIT_ZERO=1).
module tb_axi_sram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, rresp, awburst, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axi_sram_slave #(.ADDR_W(10), .INIT_ZERO(1)) dut (
    .clk(clk), .reset(reset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Bus helpers: drive at negedge, handshake on the following posedge, return at the next negedge.
  task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                         input logic [1:0] b);
    awid = id; awaddr = a; awlen = l; awburst = b; awsize = 3'd2; awvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (awready) begin
        @(posedge clk); @(negedge clk); awvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    awvalid = 1'b0; tests++; fails++;
    $display("FAIL aw_timeout: awready got 0, required 1 within 50 cycles");
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                         input logic [1:0] b);
    arid = id; araddr = a; arlen = l; arburst = b; arsize = 3'd2; arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (arready && !awvalid) begin
        @(posedge clk); @(negedge clk); arvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    arvalid = 1'b0; tests++; fails++;
    $display("FAIL ar_timeout: arready got 0, required 1 within 50 cycles");
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic l);
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (wready) begin
        @(posedge clk); @(negedge clk); wvalid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    wvalid = 1'b0; tests++; fails++;
    $display("FAIL w_timeout: wready got 0, required 1 within 50 cycles");
  endtask

  task automatic recv_b(output logic [3:0] id, output logic [1:0] resp);
    id = 'x; resp = 'x;
    for (int i = 0; i < 50; i++) begin
      if (bvalid) begin
        id = bid; resp = bresp; bready = 1'b1;
        @(posedge clk); @(negedge clk); bready = 1'b0;
        return;
      end
      @(negedge clk);
    end
    tests++; fails++;
    $display("FAIL b_timeout: bvalid got 0, required 1 within 50 cycles");
  endtask

  // Waits for rvalid, optionally stalls 'hold' cycles noting whether R stayed stable, then accepts.
  task automatic recv_r(input int hold, output logic [31:0] d, output logic [3:0] id,
                        output logic [1:0] resp, output logic last, output logic stable);
    d = 'x; id = 'x; resp = 'x; last = 'x; stable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rvalid) begin
        d = rdata; id = rid; resp = rresp; last = rlast; stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          if (!rvalid || rdata !== d || rlast !== last) stable = 1'b0;
        end
        rready = 1'b1;
        @(posedge clk); @(negedge clk); rready = 1'b0;
        return;
      end
      @(negedge clk);
    end
    tests++; fails++;
    $display("FAIL r_timeout: rvalid got 0, required 1 within 50 cycles");
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
    logic [3:0] id;
    send_aw(4'd0, a, 8'd0, 2'b01);
    send_w(d, s, 1'b1);
    recv_b(id, resp);
  endtask

  task automatic read_word(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    logic [3:0] id;
    logic       last, stable;
    send_ar(4'd0, a, 8'd0, 2'b01);
    recv_r(0, d, id, resp, last, stable);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({arready, awready, rvalid, wready, bvalid, rlast} !== 6'b110000) begin
      fails++;
      $display("FAIL reset_handshake: {ar,aw,rv,wr,bv,rlast} got %b, required 110000",
               {arready, awready, rvalid, wready, bvalid, rlast});
    end
    tests++;
    if ({rid, bid, rresp, bresp, rdata} !== 44'h0) begin
      fails++;
      $display("FAIL reset_regs: rid=%h bid=%h rresp=%h bresp=%h rdata=%h, required all 0",
               rid, bid, rresp, bresp, rdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write_read;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic [31:0] d;
    logic        last, stable;
    send_aw(4'd2, 32'h40, 8'd0, 2'b01);
    send_w(32'hDEADBEEF, 4'hF, 1'b1);
    recv_b(id, resp);
    tests++;
    if (id !== 4'd2 || resp !== 2'b00) begin
      fails++;
      $display("FAIL single_b: bid=%h bresp=%h, required bid=2 bresp=0", id, resp);
    end
    send_ar(4'd1, 32'h40, 8'd0, 2'b01);
    tests++;
    if (rvalid !== 1'b0) begin
      fails++;
      $display("FAIL single_latency1: rvalid one cycle after AR got %b, required 0", rvalid);
    end
    @(negedge clk);
    tests++;
    if (rvalid !== 1'b1) begin
      fails++;
      $display("FAIL single_latency2: rvalid two cycles after AR got %b, required 1", rvalid);
    end
    recv_r(0, d, id, resp, last, stable);
    tests++;
    if (d !== 32'hDEADBEEF || id !== 4'd1 || last !== 1'b1 || resp !== 2'b00) begin
      fails++;
      $display("FAIL single_r: rdata=%h rid=%h rlast=%b rresp=%h, required DEADBEEF 1 1 0",
               d, id, last, resp);
    end
  endtask

  task automatic test_byte_strobe;
    logic [1:0]  resp;
    logic [31:0] d;
    write_word(32'h40, 32'h11223344, 4'h5, resp);
    read_word(32'h40, d, resp);
    tests++;
    if (d !== 32'hDE22BE44) begin
      fails++;
      $display("FAIL byte_strobe: rdata=%h, required DE22BE44", d);
    end
  endtask

  task automatic test_simultaneous;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic [31:0] d;
    logic        last, stable;
    arid = 4'd4; araddr = 32'h80; arlen = 8'd0; arburst = 2'b01; arsize = 3'd2; arvalid = 1'b1;
    send_aw(4'd3, 32'h80, 8'd0, 2'b01);
    tests++;
    if (arready !== 1'b0 || wready !== 1'b1) begin
      fails++;
      $display("FAIL tie_write_first: arready=%b wready=%b, required 0 1", arready, wready);
    end
    send_w(32'hCAFEF00D, 4'hF, 1'b1);
    recv_b(id, resp);
    tests++;
    if (id !== 4'd3 || resp !== 2'b00) begin
      fails++;
      $display("FAIL tie_b: bid=%h bresp=%h, required 3 0", id, resp);
    end
    send_ar(4'd4, 32'h80, 8'd0, 2'b01);
    recv_r(0, d, id, resp, last, stable);
    tests++;
    if (d !== 32'hCAFEF00D || id !== 4'd4) begin
      fails++;
      $display("FAIL tie_r: rdata=%h rid=%h, required CAFEF00D 4", d, id);
    end
  endtask

  task automatic test_incr_wrap;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic [31:0] d;
    logic        last, stable;
    logic [31:0] pat [4] = '{32'hA0A0_0000, 32'hA1A1_0001, 32'hA2A2_0002, 32'hA3A3_0003};
    send_aw(4'd0, 32'hFF8, 8'd3, 2'b01);
    for (int k = 0; k < 4; k++) send_w(pat[k], 4'hF, k == 3);
    recv_b(id, resp);
    tests++;
    if (resp !== 2'b00) begin
      fails++;
      $display("FAIL wrap_b: bresp=%h, required 0", resp);
    end
    send_ar(4'd5, 32'hFF8, 8'd3, 2'b01);
    for (int k = 0; k < 4; k++) begin
      recv_r((k == 1) ? 3 : 0, d, id, resp, last, stable);
      tests++;
      if (d !== pat[k] || id !== 4'd5 || last !== (k == 3) || resp !== 2'b00 || !stable) begin
        fails++;
        $display("FAIL wrap_beat%0d: rdata=%h rid=%h rlast=%b rresp=%h stable=%b, required %h 5 %b 0 1",
                 k, d, id, last, resp, stable, pat[k], k == 3);
      end
    end
    read_word(32'h0, d, resp);
    tests++;
    if (d !== 32'hA2A2_0002) begin
      fails++;
      $display("FAIL wrap_word0: rdata=%h, required A2A20002", d);
    end
  endtask

  task automatic test_fixed_and_bad_burst;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic [31:0] d;
    logic        last, stable;
    send_aw(4'd0, 32'h100, 8'd1, 2'b00);
    send_w(32'h1, 4'hF, 1'b0);
    send_w(32'h2, 4'hF, 1'b1);
    recv_b(id, resp);
    read_word(32'h100, d, resp);
    tests++;
    if (d !== 32'h2) begin
      fails++;
      $display("FAIL fixed_word: rdata=%h, required 2", d);
    end
    read_word(32'h104, d, resp);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL fixed_next: rdata=%h, required 0", d);
    end
    send_aw(4'd6, 32'h40, 8'd0, 2'b10);
    send_w(32'h0, 4'hF, 1'b1);
    recv_b(id, resp);
    tests++;
    if (resp !== 2'b10 || id !== 4'd6) begin
      fails++;
      $display("FAIL bad_wburst: bresp=%h bid=%h, required 2 6", resp, id);
    end
    read_word(32'h40, d, resp);
    tests++;
    if (d !== 32'hDE22BE44) begin
      fails++;
      $display("FAIL bad_wburst_nowrite: rdata=%h, required DE22BE44", d);
    end
    send_ar(4'd7, 32'h40, 8'd0, 2'b11);
    recv_r(0, d, id, resp, last, stable);
    tests++;
    if (resp !== 2'b10 || last !== 1'b1) begin
      fails++;
      $display("FAIL bad_rburst: rresp=%h rlast=%b, required 2 1", resp, last);
    end
  endtask

  task automatic test_early_wlast_and_reset;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic [31:0] d;
    send_aw(4'd0, 32'h200, 8'd1, 2'b01);
    send_w(32'h55, 4'hF, 1'b1);
    recv_b(id, resp);
    tests++;
    if (resp !== 2'b10) begin
      fails++;
      $display("FAIL early_wlast_b: bresp=%h, required 2", resp);
    end
    read_word(32'h204, d, resp);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL early_wlast_one_word: word 0x81 rdata=%h, required 0", d);
    end
    send_ar(4'd9, 32'h200, 8'd0, 2'b01);
    @(negedge clk);
    tests++;
    if (rvalid !== 1'b1 || rdata !== 32'h55) begin
      fails++;
      $display("FAIL pre_reset_r: rvalid=%b rdata=%h, required 1 00000055", rvalid, rdata);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (rvalid !== 1'b0 || arready !== 1'b1 || rdata !== 32'h0 || rid !== 4'h0) begin
      fails++;
      $display("FAIL async_reset: rvalid=%b arready=%b rdata=%h rid=%h, required 0 1 0 0",
               rvalid, arready, rdata, rid);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    read_word(32'h200, d, resp);
    tests++;
    if (d !== 32'h55) begin
      fails++;
      $display("FAIL mem_kept: rdata=%h, required 00000055", d);
    end
  endtask

  initial begin
    reset = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    rready = 1'b0; bready = 1'b0;
    @(negedge clk);
    test_reset;
    test_single_write_read;
    test_byte_strobe;
    test_simultaneous;
    test_incr_wrap;
    test_fixed_and_bad_burst;
    test_early_wlast_and_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter ADDR_W, default 10, sets word-address width; storage is 2^ADDR_W x 32-bit words.
REQ-002 Parameter INIT_ZERO, default 1; when 1, storage is cleared to 0 at time zero (simulation only).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 AR  in: arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arvalid 1; out: arready 1.
REQ-006 R  out: rid 4, rdata 32, rresp 2, rlast 1, rvalid 1; in: rready 1.
REQ-007 AW  in: awid 4, awaddr 32, awlen 8, awsize 3, awburst 2, awvalid 1; out: awready 1.
REQ-008 W  in: wid 4 (ignored), wdata 32, wstrb 4, wlast 1, wvalid 1; out: wready 1.
REQ-009 B  out: bid 4, bresp 2, bvalid 1; in: bready 1.

Function
REQ-010 The FSM SHALL have states IDLE, RD_MEM, RD_RESP, WR_DATA and WR_RESP, with exactly one transaction in flight.
REQ-011 In IDLE, arready and awready SHALL both be 1; no other state SHALL assert either.
REQ-012 In IDLE with awvalid=1, the AW handshake SHALL be taken: latch awid, awaddr[ADDR_W+1:2], awlen and awburst, then go to WR_DATA.
- Write wins over a simultaneous arvalid; the read stays pending and is accepted on the next IDLE cycle.
REQ-013 In IDLE with arvalid=1 and awvalid=0, the AR handshake SHALL be taken: latch arid, the address, arlen and arburst, then go to RD_MEM.
REQ-014 In RD_MEM, one synchronous memory read SHALL be issued; the next cycle SHALL be RD_RESP with rvalid=1 and rdata=mem[addr].
REQ-015 In RD_RESP, R outputs SHALL hold stable until rready=1.
- On the handshake, rlast=1 when beat count == len.
- If this was not the last beat: advance the address and return to RD_MEM.
- If it was the last beat: return to IDLE.
- Latency from AR handshake to first rvalid is 2 cycles; from each R handshake to the next rvalid is 2 cycles.
REQ-016 In WR_DATA, wready SHALL be 1; on each W handshake, mem[addr] byte lanes enabled by wstrb SHALL be written, and the address SHALL advance.
REQ-017 The write burst SHALL end on the first beat with wlast=1 or on beat len+1, whichever comes first, and then go to WR_RESP.
- If wlast and the beat count disagree, bresp SHALL be SLVERR (2'b10).
REQ-018 In WR_RESP, bvalid=1 and bid=latched awid; bvalid SHALL hold until bready=1, then return to IDLE.
REQ-019 Address advance rules:
- INCR (2'b01): word address +1, wrapping modulo 2^ADDR_W.
- FIXED (2'b00): no change.
- Other burst types: the address is not advanced, memory is not written, and rresp/bresp=SLVERR.
REQ-020 Supported bursts SHALL return rresp/bresp OKAY (2'b00).
- arsize/awsize values other than 3'd2 SHALL still be served as 32-bit beats.
- rid SHALL equal the latched arid.
REQ-021 Beat counters SHALL be 8 bits wide, supporting len 0..255.

Reset
REQ-022 On reset=1, regardless of the clock, the FSM SHALL go to IDLE.
- arready, awready = 1; rvalid, wready, bvalid, rlast = 0; rid, bid, rresp, bresp, rdata = 0.
REQ-023 Reset mid-burst SHALL abandon the transaction; memory words already written SHALL be kept.

Configuration
REQ-024 With macro AXI_SLAVE_STALL_EN defined, a 16-bit LFSR (seed 16'hACE1, reset to the seed) SHALL gate arready, awready, wready and the R/B valid assertion.
- Each gated signal is asserted only on cycles where LFSR bit 0 = 1.
- Once rvalid or bvalid is asserted, it SHALL NOT be deasserted before its handshake.
REQ-025 Without AXI_SLAVE_STALL_EN, no LFSR SHALL exist and the timing SHALL be exactly as in REQ-011 to REQ-018.

Verification
REQ-026 Single write then read:
- AW id=2, addr=0x40, len=0; W data=0xDEADBEEF, strb=0xF, wlast=1 -> B id=2, OKAY.
- AR id=1, addr=0x40 -> rdata=0xDEADBEEF, rid=1, rlast=1, rvalid 2 cycles after the AR handshake.
REQ-027 Byte strobe: memory word 0x40 holds 0xDEADBEEF; write 0x11223344 with strb=0x5 -> a later read returns 0xDE22BE44.
REQ-028 Simultaneous arvalid and awvalid in IDLE:
- AW is accepted first and B completes.
- AR is then accepted.
- The read returns the newly written data.
REQ-029 INCR read burst addr=0xFF8, len=3, ADDR_W=10 -> reads words 0x3FE, 0x3FF, 0x000, 0x001; rlast only on the 4th beat.
- Holding rready=0 for 3 cycles keeps rdata stable.
REQ-030 Write with awlen=1 and wlast=1 on beat 1 -> one word written, bresp=SLVERR.
- Then assert reset mid-RD_RESP -> rvalid=0 and arready=1 immediately (asynchronously).
